// File: rtl/delay_chain_arbiter_if.sv
// Handshake bundle between the requesters, the shared delay chain and the
// single downstream consumer. The chain itself sits on the slave side.
interface delay_chain_arbiter_if #(
    parameter int DW   = 8,
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               out_valid;
    logic [DW-1:0]      out_data;
    logic [IDW-1:0]     out_id;
    logic               out_ready;

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_id
    );

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_id
    );
endinterface

// File: rtl/delay_chain_arbiter.sv
// Fixed-latency LEN-stage delay chain shared by NREQ requesters through a
// round-robin arbiter. Each stage carries {valid, source id, word}; the tail
// stage is presented to one consumer with a valid/ready handshake. A stall
// at the tail freezes the whole chain, bubbles included, so spacing between
// words is preserved exactly.
module delay_chain_arbiter #(
    parameter int DW   = 8,
    parameter int LEN  = 5,
    parameter int NREQ = 4,
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int OCW = $clog2(LEN + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    delay_chain_arbiter_if.slave bus,
    output logic [OCW-1:0]       occupancy,
    output logic                 busy
);

    localparam logic [IDW:0] NREQ_W = (IDW + 1)'(NREQ);

    logic [LEN-1:0] v;
    logic [LEN-1:0] v_next;
    logic [IDW-1:0] id_q   [LEN];
    logic [DW-1:0]  data_q [LEN];

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] winner;
    logic [IDW-1:0] ptr_wrap;
    logic [IDW:0]   ptr_inc;
    logic           any_req;
    logic [DW-1:0]  win_data;
    logic           adv;

    // The chain moves whenever the tail is empty or being taken.
    assign adv = !v[LEN-1] || bus.out_ready;

    // Round-robin search: first valid requester at or after ptr, wrapping.
    always_comb begin
        logic [IDW:0] idx;
        idx     = '0;
        any_req = 1'b0;
        winner  = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, ptr} + (IDW + 1)'(k);
            if (idx >= NREQ_W) begin
                idx = idx - NREQ_W;
            end
            if (!any_req && bus.req_valid[idx[IDW-1:0]]) begin
                any_req = 1'b1;
                winner  = idx[IDW-1:0];
            end
        end
    end

    // Select the winning requester's word.
    always_comb begin
        win_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winner == IDW'(i)) begin
                win_data = bus.req_data[i*DW +: DW];
            end
        end
    end

    // Grant is one-hot to the winner only when stage 0 can take a word.
    always_comb begin
        bus.req_ready = '0;
        if (!rst && adv && any_req) begin
            bus.req_ready[winner] = 1'b1;
        end
    end

    // Pointer moves to the requester after the one just granted.
    assign ptr_inc  = {1'b0, winner} + (IDW + 1)'(1);
    assign ptr_wrap = (ptr_inc >= NREQ_W) ? '0 : ptr_inc[IDW-1:0];

    // Next valid vector; occupancy is registered from it.
    always_comb begin
        v_next = v;
        if (adv) begin
            for (int k = LEN - 1; k > 0; k--) begin
                v_next[k] = v[k-1];
            end
            v_next[0] = any_req;
        end
    end

    // Chain shift, arbiter pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            v         <= '0;
            ptr       <= '0;
            occupancy <= '0;
            busy      <= 1'b0;
            for (int k = 0; k < LEN; k++) begin
                id_q[k]   <= '0;
                data_q[k] <= '0;
            end
        end else begin
            v         <= v_next;
            occupancy <= OCW'($countones(v_next));
            busy      <= |v_next;
            if (adv) begin
                for (int k = LEN - 1; k > 0; k--) begin
                    id_q[k]   <= id_q[k-1];
                    data_q[k] <= data_q[k-1];
                end
                // A bubble leaves id/data of stage 0 untouched.
                if (any_req) begin
                    id_q[0]   <= winner;
                    data_q[0] <= win_data;
                    ptr       <= ptr_wrap;
                end
            end
        end
    end

    assign bus.out_valid = v[LEN-1];
    assign bus.out_data  = data_q[LEN-1];
    assign bus.out_id    = id_q[LEN-1];

endmodule

// File: tb/tb_delay_chain_arbiter.sv
// Bench for delay_chain_arbiter: directed scenarios followed by a random
// phase, with a queue of accepted words compared against the tail output.
module tb_delay_chain_arbiter;

    localparam int DW   = 8;
    localparam int LEN  = 5;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int OCW  = $clog2(LEN + 1);

    logic           clk;
    logic           rst;
    logic [OCW-1:0] occupancy;
    logic           busy;

    int vectors = 0;
    int errors  = 0;

    logic [IDW+DW-1:0] sb[$];

    delay_chain_arbiter_if #(.DW(DW), .NREQ(NREQ), .IDW(IDW)) bus ();

    delay_chain_arbiter #(.DW(DW), .LEN(LEN), .NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .occupancy (occupancy),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bus.req_valid = '0;
        bus.out_ready = 1'b1;
        repeat (LEN + 1) step();
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        bus.req_valid = '0;
        step();
        rst = 1'b0;
    endtask

    // Scoreboard: pop on consumer handshake, push on requester handshake.
    always @(negedge clk) begin
        logic [IDW+DW-1:0] ent;
        ent = '0;
        if (rst) begin
            sb.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                check("sb_nonempty", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    ent = sb.pop_front();
                    check("sb_data", bus.out_data, ent[DW-1:0]);
                    check("sb_id", bus.out_id, ent[IDW+DW-1:DW]);
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    sb.push_back({IDW'(i), bus.req_data[i*DW +: DW]});
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int e;
        int rr;
        logic exp_adv;
        logic [NREQ-1:0] exp_rdy;
        logic [NREQ-1:0] pend;
        logic [DW-1:0] pdata [NREQ];
        logic found;
        int j;
        int occ;

        rst           = 1'b1;
        bus.req_valid = 4'b1111;
        bus.req_data  = 32'h33221100;
        bus.out_ready = 1'b1;

        // Reset held with everyone requesting.
        step();
        for (int r = 0; r < 3; r++) begin
            #1;
            check("rst_ready", bus.req_ready, 4'b0000);
            check("rst_out_valid", bus.out_valid, 0);
            check("rst_occupancy", occupancy, 0);
            check("rst_busy", busy, 0);
            step();
        end
        rst = 1'b0;

        // Requester 2 alone sends 0xA5.
        bus.req_valid = 4'b0100;
        bus.req_data  = 32'h00A50000;
        #1;
        check("single_ready", bus.req_ready, 4'b0100);
        step();
        bus.req_valid = '0;
        for (int n = 1; n <= LEN + 1; n++) begin
            #1;
            check("single_valid", bus.out_valid, 32'(n == LEN));
            if (n == LEN) begin
                check("single_data", bus.out_data, 8'hA5);
                check("single_id", bus.out_id, 2);
            end
            step();
        end

        // All four request continuously; stall the full chain for 3 cycles.
        reset_pulse();
        bus.req_valid = 4'b1111;
        bus.req_data  = 32'h33221100;
        g = 0;
        e = 0;
        for (int n = 0; n < 22; n++) begin
            bus.out_ready = !(n >= 12 && n < 15);
            #1;
            exp_adv = (n < LEN) || bus.out_ready;
            exp_rdy = exp_adv ? (4'b0001 << g) : 4'b0000;
            check("rr_ready", bus.req_ready, exp_rdy);
            check("rr_out_valid", bus.out_valid, 32'(n >= LEN));
            check("rr_occupancy", occupancy, (n < LEN) ? n : LEN);
            if (n >= LEN) begin
                check("rr_out_id", bus.out_id, e % 4);
                check("rr_out_data", bus.out_data, (e % 4) * 8'h11);
            end
            step();
            if (exp_adv) g = (g + 1) % 4;
            if (n >= LEN && bus.out_ready) e++;
        end
        drain();

        // Three words in flight, then a one-cycle reset.
        bus.req_valid = 4'b0010;
        bus.req_data  = 32'h0000BB00;
        for (int n = 0; n < 3; n++) begin
            #1;
            check("flight_ready", bus.req_ready, 4'b0010);
            step();
        end
        rst = 1'b1;
        bus.req_valid = '0;
        step();
        rst = 1'b0;
        for (int n = 0; n < LEN + 2; n++) begin
            #1;
            check("flush_valid", bus.out_valid, 0);
            check("flush_occupancy", occupancy, 0);
            check("flush_busy", busy, 0);
            step();
        end
        bus.req_valid = 4'b1111;
        bus.req_data  = 32'h44332211;
        #1;
        check("post_rst_ready", bus.req_ready, 4'b0001);
        step();
        drain();

        // Requests in cycles 0 and 2: the bubble between them survives.
        for (int n = 0; n < 9; n++) begin
            bus.req_valid = (n == 0 || n == 2) ? 4'b1000 : 4'b0000;
            bus.req_data  = {8'(8'h60 + n), 24'h0};
            #1;
            occ = ((n >= 1 && n <= LEN) ? 1 : 0) + ((n >= 3 && n <= LEN + 2) ? 1 : 0);
            check("bubble_valid", bus.out_valid, 32'(n == LEN || n == LEN + 2));
            check("bubble_occupancy", occupancy, occ);
            step();
        end

        // Random traffic with held requests and random back-pressure.
        reset_pulse();
        rr   = 0;
        pend = '0;
        for (int i = 0; i < NREQ; i++) pdata[i] = '0;
        for (int c = 0; c < 2000; c++) begin
            check("rand_occupancy", occupancy, sb.size());
            check("rand_busy", busy, 32'(sb.size() != 0));
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i]  = 1'b1;
                    pdata[i] = 8'($urandom);
                end
            end
            bus.req_valid = pend;
            for (int i = 0; i < NREQ; i++) bus.req_data[i*DW +: DW] = pdata[i];
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_adv = !bus.out_valid || bus.out_ready;
            exp_rdy = '0;
            found   = 1'b0;
            for (int k = 0; k < NREQ; k++) begin
                j = (rr + k) % NREQ;
                if (!found && pend[j]) begin
                    found = 1'b1;
                    if (exp_adv) exp_rdy[j] = 1'b1;
                end
            end
            check("rand_grant", bus.req_ready, exp_rdy);
            step();
            for (int i = 0; i < NREQ; i++) begin
                if (exp_rdy[i]) rr = (i + 1) % NREQ;
            end
            pend = pend & ~exp_rdy;
        end

        // Everything accepted must come out.
        bus.req_valid = '0;
        bus.out_ready = 1'b1;
        for (int n = 0; n < LEN + 2 && sb.size() != 0; n++) step();
        #1;
        check("final_drain", sb.size(), 0);
        check("final_occupancy", occupancy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
